// File: rtl/load_wb_pkg.sv
// Shared definitions for the load/writeback stage: writeback mode encodings,
// FSM state type and per-mode access size / signedness helpers.
package load_wb_pkg;

    localparam logic [2:0] MODE_ALU = 3'b000;
    localparam logic [2:0] MODE_LD  = 3'b001;
    localparam logic [2:0] MODE_LB  = 3'b010;
    localparam logic [2:0] MODE_LH  = 3'b011;
    localparam logic [2:0] MODE_LBU = 3'b100;
    localparam logic [2:0] MODE_LHU = 3'b101;
    localparam logic [2:0] MODE_LW  = 3'b110;
    localparam logic [2:0] MODE_LWU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_WB    = 3'd5
    } state_e;

    // Access size in bytes; full-width loads (and ALU) report the word size.
    function automatic int unsigned size_of_mode(input logic [2:0] mode,
                                                 input int unsigned nbytes);
        case (mode)
            MODE_LB, MODE_LBU: return 1;
            MODE_LH, MODE_LHU: return 2;
            MODE_LW, MODE_LWU: return 4;
            default:           return nbytes;
        endcase
    endfunction

    // Loads whose result is sign-extended.
    function automatic logic is_signed_mode(input logic [2:0] mode);
        return (mode == MODE_LD) || (mode == MODE_LB) ||
               (mode == MODE_LH) || (mode == MODE_LW);
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load aligner: picks the addressed bytes out of the two-beat
// window {beat1, beat0}, then sign- or zero-extends them to XLEN.
// Ports: beat0/beat1 raw memory words, offset byte offset within beat0,
//        mode (already normalised for XLEN), data_c aligned/extended result.
module load_align_extend
    import load_wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] beat0,
    input  logic [XLEN-1:0] beat1,
    input  logic [OFFW-1:0] offset,
    input  logic [2:0]      mode,
    output logic [XLEN-1:0] data_c
);

    localparam int unsigned BYTES = XLEN / 8;

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] keep_mask;
    int unsigned     nbits;
    logic            sign_bit;

    always_comb begin
        raw       = XLEN'({beat1, beat0} >> {offset, 3'b000});
        nbits     = 8 * size_of_mode(mode, BYTES);
        keep_mask = {XLEN{1'b1}} >> (XLEN - nbits);
        case (nbits)
            8:       sign_bit = raw[7];
            16:      sign_bit = raw[15];
            32:      sign_bit = raw[31];
            default: sign_bit = raw[XLEN-1];
        endcase
        if (!is_signed_mode(mode)) begin
            sign_bit = 1'b0;
        end
        data_c = (raw & keep_mask) | ({XLEN{sign_bit}} & ~keep_mask);
    end

endmodule

// File: rtl/load_wb_unit.sv
// Load/writeback stage between EX/MEM and the register-file write port.
// ALU results pass through; loads are fetched over a valid/ready memory port
// (split into two beats when crossing a word boundary), aligned, extended and
// written back as a one-cycle wb_valid pulse.
// Ports: req_* request from EX/MEM (req_ready = idle), mem_* memory read port,
//        wb_* registered writeback (wb_fault flags a misaligned load).
module load_wb_unit
    import load_wb_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_mode,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_alu_result,
    input  logic [4:0]      req_rd,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fault
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);

    state_e          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [OFFW-1:0] offset_q, offset_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] beat0_q, beat0_d;
    logic            req_ready_q, req_ready_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_fault_q, wb_fault_d;

    logic [2:0]      req_mode_eff;
    int unsigned     req_size;
    int unsigned     cur_size;
    logic            req_misaligned;
    logic            two_beat;
    logic [XLEN-1:0] align_beat0;
    logic [XLEN-1:0] align_beat1;
    logic [XLEN-1:0] align_data;

    // Request decode: on 32-bit datapaths the word loads are full-width loads.
    always_comb begin
        req_mode_eff = req_mode;
        if ((XLEN == 32) && ((req_mode == MODE_LW) || (req_mode == MODE_LWU))) begin
            req_mode_eff = MODE_LD;
        end
        req_size       = size_of_mode(req_mode_eff, BYTES);
        req_misaligned = (req_addr[OFFW-1:0] & OFFW'(req_size - 1)) != '0;
        cur_size       = size_of_mode(mode_q, BYTES);
        two_beat       = (32'(offset_q) + cur_size) > BYTES;
    end

    // The aligner sees the beat arriving this cycle so WB data is ready on entry.
    assign align_beat0 = (state_q == ST_WAIT1) ? beat0_q   : mem_rdata;
    assign align_beat1 = (state_q == ST_WAIT1) ? mem_rdata : '0;

    load_align_extend #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_align (
        .beat0  (align_beat0),
        .beat1  (align_beat1),
        .offset (offset_q),
        .mode   (mode_q),
        .data_c (align_data)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        offset_d   = offset_q;
        rd_d       = rd_q;
        beat0_d    = beat0_q;
        mem_addr_d = mem_addr_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_fault_d = wb_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    mode_d   = req_mode_eff;
                    offset_d = req_addr[OFFW-1:0];
                    rd_d     = req_rd;
                    if (req_mode_eff == MODE_ALU) begin
                        state_d    = ST_WB;
                        wb_data_d  = req_alu_result;
                        wb_rd_d    = req_rd;
                        wb_fault_d = 1'b0;
                    end else if (!ALLOW_MISALIGNED && req_misaligned) begin
                        state_d    = ST_WB;
                        wb_data_d  = '0;
                        wb_rd_d    = req_rd;
                        wb_fault_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ0;
                        mem_addr_d = {req_addr[XLEN-1:OFFW], OFFW'(0)};
                    end
                end
            end
            ST_REQ0: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (mem_rsp_valid) begin
                    beat0_d = mem_rdata;
                    if (two_beat) begin
                        state_d    = ST_REQ1;
                        mem_addr_d = mem_addr_q + XLEN'(BYTES);
                    end else begin
                        state_d    = ST_WB;
                        wb_data_d  = align_data;
                        wb_rd_d    = rd_q;
                        wb_fault_d = 1'b0;
                    end
                end
            end
            ST_REQ1: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (mem_rsp_valid) begin
                    state_d    = ST_WB;
                    wb_data_d  = align_data;
                    wb_rd_d    = rd_q;
                    wb_fault_d = 1'b0;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they register cleanly.
        req_ready_d     = (state_d == ST_IDLE);
        mem_req_valid_d = (state_d == ST_REQ0) || (state_d == ST_REQ1);
        wb_valid_d      = (state_d == ST_WB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            mode_q          <= MODE_ALU;
            offset_q        <= '0;
            rd_q            <= '0;
            beat0_q         <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            wb_fault_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            offset_q        <= offset_d;
            rd_q            <= rd_d;
            beat0_q         <= beat0_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            wb_fault_q      <= wb_fault_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_fault      = wb_fault_q;

endmodule

// File: doc/load_wb_unit.md
# load_wb_unit

- Parametrised load/writeback stage that replaces the fixed 32-bit ALU/memory writeback select.
- Accepts one writeback request at a time.
  - ALU results pass straight through.
  - Loads fetch from data memory through a valid/ready request port, including two-beat accesses that cross a word boundary.
- Loaded data is aligned and sign- or zero-extended, then presented to the register file as a one-cycle writeback pulse.
- Sits between EX/MEM and the register-file write port.

## Interface
Parameters:
- XLEN, 32: datapath width, 32 or 64; BYTES = XLEN/8.
- ALLOW_MISALIGNED, 1: 1 = split boundary-crossing loads into two beats; 0 = fault on non-natural alignment.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_mode  in  3  writeback mode, encoded below.
- req_addr  in  XLEN  byte address (loads only).
- req_alu_result  in  XLEN  ALU result (mode 000).
- req_rd  in  5  destination register.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  XLEN  word-aligned address (low log2(BYTES) bits zero).
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  writeback value.
- wb_fault  out  1  misaligned-load fault; qualified by wb_valid.

Modes:
- 000: ALU result.
- 001: full XLEN load.
- 010: LB.
- 011: LH.
- 100: LBU.
- 101: LHU.
- 110: LW, sign-extended (XLEN=64).
- 111: LWU (XLEN=64).
- With XLEN=32, modes 110 and 111 behave as 001.

## Operation
- Request handshake: accepted when req_valid && req_ready. The unit latches mode, addr, alu_result and rd.
- State machine: IDLE, REQ0, WAIT0, REQ1, WAIT1, WB.
- Transitions:
  - IDLE: on accept, mode 000 → WB; load → REQ0. If ALLOW_MISALIGNED=0 and addr % size != 0 → WB with fault set; no memory access is issued.
  - REQ0: mem_req_valid=1, mem_addr = addr with the low bits cleared. On mem_req_ready → WAIT0.
  - WAIT0: on mem_rsp_valid, capture beat0. If offset+size > BYTES → REQ1, else → WB.
  - REQ1: mem_addr = aligned addr + BYTES, wrapping modulo 2^XLEN. On mem_req_ready → WAIT1.
  - WAIT1: on mem_rsp_valid, capture beat1 → WB.
  - WB: wb_valid=1 for one cycle → IDLE.
- Size by mode: 1 byte (010, 100), 2 bytes (011, 101), 4 bytes (110, 111), BYTES (001).
- Alignment: form {beat1, beat0} (2·XLEN bits); beat1 = 0 for single-beat loads. Shift right by offset·8 and take the low size·8 bits.
- Extension: sign-extend for 001/010/011/110, zero-extend for 100/101/111. Mode 000 passes req_alu_result unchanged.
- Fault: wb_fault=1 with wb_data=0 and wb_rd=latched rd. The register file decides whether to suppress the write.
- mem_rsp_valid outside WAIT0/WAIT1 is ignored.
- Only one memory request is ever outstanding.
- Reset, including mid-transaction: the state returns to IDLE and all outputs clear asynchronously. Any in-flight response is dropped.

## Timing
- Reset values:
  - req_ready = 1.
  - mem_req_valid, wb_valid, wb_fault = 0.
  - mem_addr, wb_data = 0.
  - wb_rd = 0.
- ALU mode: accept at cycle N → wb_valid at N+1.
- Single-beat load with zero-wait memory (ready held high, rsp one cycle after request accept):
  - mem_req_valid at N+1.
  - rsp at N+2.
  - wb_valid at N+3.
- Two-beat load: each extra beat adds 2 cycles, so wb_valid at N+5 under the same conditions.
- Fault path: wb_valid at N+1.
- Backpressure: mem_req_valid and mem_addr stay stable while mem_req_ready is low.
- req_ready = 1 only in IDLE. Back-to-back requests are therefore separated by at least one WB cycle.
- wb_* outputs are registered; wb_data and wb_rd hold their values until the next WB.

## Structure
- Package load_wb_pkg holds:
  - the mode constants (MODE_ALU … MODE_LWU);
  - the state enum;
  - a size_of_mode function.
- Sub-module load_align_extend is purely combinational. It takes beat0, beat1, offset and mode and produces the aligned, extended value. The FSM and registers stay in load_wb_unit.

## Test plan
- ALU pass-through: mode 000, alu_result=0xDEADBEEF, rd=5 → wb_valid at N+1 with wb_data=0xDEADBEEF, wb_rd=5, no mem_req_valid.
- LB sign: XLEN=32, addr=0x1003, mem_rdata=0x80112233 → mem_addr=0x1000, wb_data=0xFFFFFF80. Same stimulus with LBU → 0x00000080.
- Boundary-crossing LH: addr=0x1003, beat0=0xAA000000, beat1=0x000000BB → mem_addr 0x1000 then 0x1004, wb_data=0xFFFFBBAA, wb_valid at N+5.
- Misaligned fault: ALLOW_MISALIGNED=0, LH at addr=0x2001 → wb_valid at N+1, wb_fault=1, wb_data=0, no memory request.
- Backpressure: hold mem_req_ready low 3 cycles → mem_req_valid and mem_addr stable throughout, req_ready=0, correct data afterwards. XLEN=64 LWU of 0x80000000 → 0x0000000080000000.
- Reset mid-load: assert rst_n=0 in WAIT0 → outputs at reset values immediately. A later mem_rsp_valid produces no wb_valid, and req_ready=1 after release.
